alu_reservation_station: RTL and testbench

//  Holds dispatched non-memory ops downstream of the reorder buffer until both source operands are known.

---
 rtl/alu_reservation_station_pkg.sv | 21 ++
 rtl/rs_prio_pick.sv | 23 ++
 rtl/alu_reservation_station.sv | 106 ++++++++++
 tb/tb_alu_reservation_station.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_reservation_station_pkg.sv
// alu_reservation_station_pkg: shared opcode encodings, default tag width and op class helper
package alu_reservation_station_pkg;
    localparam int RS_TAG_W = 3;
    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_AND   = 5'b00010;
    localparam logic [4:0] OP_OR    = 5'b00011;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_SLT   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01010;
    localparam logic [4:0] OP_BEQ_C = 5'b10000;
    localparam logic [4:0] OP_JAL_C = 5'b10001;
    localparam logic [4:0] OP_LB    = 5'b10010;
    localparam logic [4:0] OP_LW    = 5'b10100;
    localparam logic [4:0] OP_SW    = 5'b11001;
    localparam logic [4:0] OP_NOP   = 5'b11111;

    function automatic logic is_mem_op(input logic [4:0] op);
        return op >= OP_LB && op <= OP_SW;
    endfunction
endpackage

// File: rtl/rs_prio_pick.sv
// rs_prio_pick: one-hot grant of the lowest-index set request bit
module rs_prio_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         any
);
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign any = |req;
endmodule

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: buffers non-memory ops until both operands arrive via
// result-bus snooping, then issues the lowest-index ready op to the ALU.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = RS_TAG_W,
    parameter int XLEN    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [4:0]       disp_op,
    input  logic [XLEN-1:0]  disp_v1,
    input  logic [XLEN-1:0]  disp_v2,
    input  logic [TAG_W-1:0] disp_q1,
    input  logic [TAG_W-1:0] disp_q2,
    input  logic [XLEN-1:0]  disp_imm,
    input  logic [TAG_W-1:0] disp_dest,
    input  logic [TAG_W-1:0] alu_bc_tag,
    input  logic [XLEN-1:0]  alu_bc_val,
    input  logic [TAG_W-1:0] mem_bc_tag,
    input  logic [XLEN-1:0]  mem_bc_val,
    output logic             rs_full,
    output logic             iss_valid,
    output logic [4:0]       iss_op,
    output logic [XLEN-1:0]  iss_a,
    output logic [XLEN-1:0]  iss_b,
    output logic [XLEN-1:0]  iss_imm,
    output logic [TAG_W-1:0] iss_dest
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] busy, ready, free_gnt, iss_gnt;
    logic [4:0]         op   [ENTRIES];
    logic [XLEN-1:0]    v1   [ENTRIES];
    logic [XLEN-1:0]    v2   [ENTRIES];
    logic [XLEN-1:0]    imm  [ENTRIES];
    logic [TAG_W-1:0]   q1   [ENTRIES];
    logic [TAG_W-1:0]   q2   [ENTRIES];
    logic [TAG_W-1:0]   dest [ENTRIES];
    logic               free_any, iss_any, disp_ok;
    logic [IDX_W-1:0]   iss_idx;

    // ALU bus checked first so it wins when both buses carry the same tag
    function automatic logic [TAG_W+XLEN-1:0] snoop(input logic [TAG_W-1:0] q, input logic [XLEN-1:0] v);
        if (q != '0 && q == alu_bc_tag) return {TAG_W'(0), alu_bc_val};
        if (q != '0 && q == mem_bc_tag) return {TAG_W'(0), mem_bc_val};
        return {q, v};
    endfunction

    always_comb begin
        ready   = '0;
        iss_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            ready[i] = busy[i] && q1[i] == '0 && q2[i] == '0;
            if (iss_gnt[i]) iss_idx = IDX_W'(i);
        end
    end

    rs_prio_pick #(.N(ENTRIES)) u_free_pick (.req(~busy), .gnt(free_gnt), .any(free_any));
    rs_prio_pick #(.N(ENTRIES)) u_iss_pick  (.req(ready),  .gnt(iss_gnt),  .any(iss_any));

    assign disp_ok = free_any && disp_op != OP_NOP && !is_mem_op(disp_op);
    assign rs_full = &busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy      <= '0;
            iss_valid <= 1'b0;
            iss_op    <= OP_NOP;
            iss_a     <= '0;
            iss_b     <= '0;
            iss_imm   <= '0;
            iss_dest  <= '0;
        end else if (flush) begin
            busy      <= '0;
            iss_valid <= 1'b0;
            iss_op    <= OP_NOP;
        end else begin
            iss_valid <= iss_any;
            iss_op    <= iss_any ? op[iss_idx] : OP_NOP;
            if (iss_any) begin
                iss_a    <= v1[iss_idx];
                iss_b    <= v2[iss_idx];
                iss_imm  <= imm[iss_idx];
                iss_dest <= dest[iss_idx];
            end
            // free_gnt only covers slots idle before the edge, so an issuing slot is not reused yet
            for (int i = 0; i < ENTRIES; i++) begin
                if (disp_ok && free_gnt[i]) begin
                    busy[i]         <= 1'b1;
                    op[i]           <= disp_op;
                    imm[i]          <= disp_imm;
                    dest[i]         <= disp_dest;
                    {q1[i], v1[i]}  <= snoop(disp_q1, disp_v1);
                    {q2[i], v2[i]}  <= snoop(disp_q2, disp_v2);
                end else begin
                    busy[i]         <= busy[i] && !iss_gnt[i];
                    {q1[i], v1[i]}  <= snoop(q1[i], v1[i]);
                    {q2[i], v2[i]}  <= snoop(q2[i], v2[i]);
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// tb_alu_reservation_station: directed checks of dispatch, wakeup, issue order, full, flush and reset
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [4:0]  disp_op;
    logic [31:0] disp_v1, disp_v2, disp_imm, alu_bc_val, mem_bc_val;
    logic [2:0]  disp_q1, disp_q2, disp_dest, alu_bc_tag, mem_bc_tag;
    logic        rs_full, iss_valid;
    logic [4:0]  iss_op;
    logic [31:0] iss_a, iss_b, iss_imm;
    logic [2:0]  iss_dest;
    int          n_cmp = 0;
    int          n_err = 0;

    alu_reservation_station dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_op(disp_op), .disp_v1(disp_v1), .disp_v2(disp_v2),
        .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_imm(disp_imm), .disp_dest(disp_dest),
        .alu_bc_tag(alu_bc_tag), .alu_bc_val(alu_bc_val),
        .mem_bc_tag(mem_bc_tag), .mem_bc_val(mem_bc_val),
        .rs_full(rs_full), .iss_valid(iss_valid), .iss_op(iss_op),
        .iss_a(iss_a), .iss_b(iss_b), .iss_imm(iss_imm), .iss_dest(iss_dest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        disp_op = OP_NOP; disp_v1 = '0; disp_v2 = '0; disp_q1 = '0; disp_q2 = '0;
        disp_imm = '0; disp_dest = '0; flush = 1'b0;
        alu_bc_tag = '0; alu_bc_val = '0; mem_bc_tag = '0; mem_bc_val = '0;
    endtask

    task automatic disp(input logic [4:0] op, input logic [31:0] v1, input logic [2:0] q1,
                        input logic [31:0] v2, input logic [2:0] q2, input logic [31:0] imm,
                        input logic [2:0] dest);
        disp_op = op; disp_v1 = v1; disp_q1 = q1; disp_v2 = v2; disp_q2 = q2;
        disp_imm = imm; disp_dest = dest;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(iss_valid), 32'd0);
        chk("rst_op", 32'(iss_op), 32'h1f);
        chk("rst_a", iss_a, 32'd0);
        chk("rst_dest", 32'(iss_dest), 32'd0);
        chk("rst_full", 32'(rs_full), 32'd0);
        rst = 1'b1;
        tick();

        // 1: ready ADD issues one edge after dispatch
        disp(OP_ADD, 32'd5, 3'd0, 32'd7, 3'd0, 32'h11, 3'd3);
        tick();
        chk("t1_not_yet", 32'(iss_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(iss_valid), 32'd1);
        chk("t1_op", 32'(iss_op), 32'(OP_ADD));
        chk("t1_a", iss_a, 32'd5);
        chk("t1_b", iss_b, 32'd7);
        chk("t1_imm", iss_imm, 32'h11);
        chk("t1_dest", 32'(iss_dest), 32'd3);
        tick();
        chk("t1_drop", 32'(iss_valid), 32'd0);
        chk("t1_op_nop", 32'(iss_op), 32'h1f);
        chk("t1_a_hold", iss_a, 32'd5);

        // 2: wait on tag 2; both buses carry tag 2, ALU value wins
        disp(OP_SUB, 32'hdead, 3'd2, 32'd1, 3'd0, 32'd0, 3'd4);
        tick();
        chk("t2_held", 32'(iss_valid), 32'd0);
        alu_bc_tag = 3'd2; alu_bc_val = 32'h10; mem_bc_tag = 3'd2; mem_bc_val = 32'h99;
        tick();
        chk("t2_wake_edge", 32'(iss_valid), 32'd0);
        tick();
        chk("t2_valid", 32'(iss_valid), 32'd1);
        chk("t2_op", 32'(iss_op), 32'(OP_SUB));
        chk("t2_a", iss_a, 32'h10);
        chk("t2_b", iss_b, 32'd1);
        chk("t2_dest", 32'(iss_dest), 32'd4);
        tick();

        // 3: producer broadcasts on the memory bus in the dispatch cycle
        disp(OP_OR, 32'd3, 3'd0, 32'd0, 3'd4, 32'd0, 3'd5);
        mem_bc_tag = 3'd4; mem_bc_val = 32'hab;
        tick();
        tick();
        chk("t3_valid", 32'(iss_valid), 32'd1);
        chk("t3_a", iss_a, 32'd3);
        chk("t3_b", iss_b, 32'hab);
        chk("t3_dest", 32'(iss_dest), 32'd5);
        tick();

        // 4: fill all four slots with blocked ops (waiting on tags 1,2,3,5)
        disp(OP_ADD, 32'd0, 3'd1, 32'h100, 3'd0, 32'd0, 3'd1); tick();
        disp(OP_ADD, 32'd0, 3'd2, 32'h101, 3'd0, 32'd0, 3'd2); tick();
        disp(OP_ADD, 32'd0, 3'd3, 32'h102, 3'd0, 32'd0, 3'd3); tick();
        chk("t4_not_full", 32'(rs_full), 32'd0);
        disp(OP_ADD, 32'd0, 3'd5, 32'h103, 3'd0, 32'd0, 3'd4); tick();
        chk("t4_full", 32'(rs_full), 32'd1);
        disp(OP_XOR, 32'd1, 3'd0, 32'd1, 3'd0, 32'd0, 3'd7); tick();
        chk("t4_fifth_ignored_full", 32'(rs_full), 32'd1);
        chk("t4_fifth_ignored_valid", 32'(iss_valid), 32'd0);
        alu_bc_tag = 3'd2; alu_bc_val = 32'h22;
        tick();
        chk("t4_wake_valid", 32'(iss_valid), 32'd0);
        chk("t4_wake_full", 32'(rs_full), 32'd1);
        tick();
        chk("t4_iss_valid", 32'(iss_valid), 32'd1);
        chk("t4_iss_dest", 32'(iss_dest), 32'd2);
        chk("t4_iss_a", iss_a, 32'h22);
        chk("t4_iss_b", iss_b, 32'h101);
        chk("t4_full_clear", 32'(rs_full), 32'd0);

        // 5: refill slot 1, then wake slots 1 and 3 together
        disp(OP_AND, 32'd0, 3'd7, 32'd9, 3'd0, 32'd0, 3'd6);
        tick();
        chk("t5_refill_full", 32'(rs_full), 32'd1);
        alu_bc_tag = 3'd5; alu_bc_val = 32'h55; mem_bc_tag = 3'd7; mem_bc_val = 32'h77;
        tick();
        tick();
        chk("t5_first_valid", 32'(iss_valid), 32'd1);
        chk("t5_first_op", 32'(iss_op), 32'(OP_AND));
        chk("t5_first_dest", 32'(iss_dest), 32'd6);
        chk("t5_first_a", iss_a, 32'h77);
        tick();
        chk("t5_second_valid", 32'(iss_valid), 32'd1);
        chk("t5_second_dest", 32'(iss_dest), 32'd4);
        chk("t5_second_a", iss_a, 32'h55);
        chk("t5_second_b", iss_b, 32'h103);
        tick();
        chk("t5_after", 32'(iss_valid), 32'd0);

        // 6: three busy, flush with concurrent dispatch and broadcast
        disp(OP_SUB, 32'd0, 3'd1, 32'd0, 3'd0, 32'd0, 3'd7);
        tick();
        chk("t6_three_busy", 32'(rs_full), 32'd0);
        disp(OP_ADD, 32'd1, 3'd0, 32'd2, 3'd0, 32'd0, 3'd5);
        alu_bc_tag = 3'd1; alu_bc_val = 32'h1;
        flush = 1'b1;
        tick();
        chk("t6_flush_valid", 32'(iss_valid), 32'd0);
        chk("t6_flush_full", 32'(rs_full), 32'd0);
        tick();
        chk("t6_flush_disp_dropped", 32'(iss_valid), 32'd0);
        alu_bc_tag = 3'd1; mem_bc_tag = 3'd3;
        tick(); tick();
        chk("t6_no_ghost", 32'(iss_valid), 32'd0);
        disp(OP_LW, 32'd1, 3'd0, 32'd2, 3'd0, 32'd0, 3'd3);
        tick(); tick();
        chk("t6_lw_ignored", 32'(iss_valid), 32'd0);
        disp(OP_NOP, 32'd1, 3'd0, 32'd2, 3'd0, 32'd0, 3'd3);
        tick(); tick();
        chk("t6_nop_ignored", 32'(iss_valid), 32'd0);

        // mid-run reset after a live issue
        disp(OP_ADD, 32'haa, 3'd0, 32'hbb, 3'd0, 32'hcc, 3'd2);
        tick(); tick();
        chk("t6_pre_rst_valid", 32'(iss_valid), 32'd1);
        chk("t6_pre_rst_a", iss_a, 32'haa);
        disp(OP_ADD, 32'd1, 3'd0, 32'd1, 3'd0, 32'd1, 3'd1);
        rst = 1'b0;
        tick();
        chk("t6_rst_valid", 32'(iss_valid), 32'd0);
        chk("t6_rst_op", 32'(iss_op), 32'h1f);
        chk("t6_rst_a", iss_a, 32'd0);
        chk("t6_rst_b", iss_b, 32'd0);
        chk("t6_rst_imm", iss_imm, 32'd0);
        chk("t6_rst_dest", 32'(iss_dest), 32'd0);
        chk("t6_rst_full", 32'(rs_full), 32'd0);
        rst = 1'b1;
        tick(); tick();
        chk("t6_rst_drop_disp", 32'(iss_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
